// File: rtl/align_ar_scheduler_if.sv
// AR/R handshake bundle between the vector-load requesters, the scheduler and the memory read port.
interface align_ar_scheduler_if #(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned AxiAddrWidth = 64
) ();
  logic [NumReq-1:0]              req_ar_valid_i;
  logic [NumReq-1:0]              req_ar_ready_o;
  logic [NumReq*AxiAddrWidth-1:0] req_ar_addr_i;
  logic [NumReq*8-1:0]            req_ar_len_i;
  logic                           mem_ar_valid_o;
  logic                           mem_ar_ready_i;
  logic [AxiAddrWidth-1:0]        mem_ar_addr_o;
  logic [7:0]                     mem_ar_len_o;
  logic                           mem_r_valid_i;
  logic                           mem_r_last_i;
  logic                           mem_r_ready_o;
  logic [NumReq-1:0]              req_r_valid_o;
  logic [NumReq-1:0]              req_r_ready_i;

  modport slave (
    input  req_ar_valid_i, req_ar_addr_i, req_ar_len_i, mem_ar_ready_i,
           mem_r_valid_i, mem_r_last_i, req_r_ready_i,
    output req_ar_ready_o, mem_ar_valid_o, mem_ar_addr_o, mem_ar_len_o,
           mem_r_ready_o, req_r_valid_o
  );

  modport master (
    output req_ar_valid_i, req_ar_addr_i, req_ar_len_i, mem_ar_ready_i,
           mem_r_valid_i, mem_r_last_i, req_r_ready_i,
    input  req_ar_ready_o, mem_ar_valid_o, mem_ar_addr_o, mem_ar_len_o,
           mem_r_ready_o, req_r_valid_o
  );
endinterface

// File: rtl/align_ar_scheduler.sv
// Round-robin AR sharing with an in-order burst tracker that steers R beats and alignment shifts.
// Optional beat-count checking is enabled by defining ALIGN_SCHED_LEN_CHECK_EN.
module align_ar_scheduler #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 256,
  parameter int unsigned NumOutstanding = 8,
  localparam int unsigned NumStages     = $clog2(AxiDataWidth/8)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  align_ar_scheduler_if.slave  bus_if,
  output logic [NumStages-1:0] shift_en_o,
  output logic                 shift_valid_o,
  output logic                 len_err_o
);

  localparam int unsigned PtrW = $clog2(NumOutstanding);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OwnW = $clog2(NumReq);

  logic [OwnW-1:0]      owner_mem_r [NumOutstanding];
  logic [NumStages-1:0] off_mem_r   [NumOutstanding];
  logic [7:0]           len_mem_r   [NumOutstanding];
  logic [PtrW-1:0]      wptr_r, rptr_r;
  logic [CntW-1:0]      cnt_r;
  logic [OwnW-1:0]      rr_ptr_r, lock_idx_r;
  logic                 lock_r;

  logic                 full_s, empty_s, win_vld_s, ar_valid_s, push_s;
  logic                 r_ready_s, r_hs_s, pop_s;
  logic [OwnW-1:0]      win_idx_s, head_owner_s;
  logic [7:0]           head_len_s;
  logic [AxiAddrWidth-1:0] win_addr_s;
  logic [7:0]           win_len_s;
  int                   k_s;

  assign full_s       = (cnt_r == CntW'(NumOutstanding));
  assign empty_s      = (cnt_r == {CntW{1'b0}});
  assign head_owner_s = owner_mem_r[rptr_r];
  assign head_len_s   = len_mem_r[rptr_r];

  // Winner selection: a locked grant wins outright, otherwise first valid requester from rr pointer.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = {OwnW{1'b0}};
    k_s       = 0;
    if (lock_r) begin
      win_vld_s = 1'b1;
      win_idx_s = lock_idx_r;
    end else begin
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
        k_s = (int'(rr_ptr_r) + i) % int'(NumReq);
        if (bus_if.req_ar_valid_i[k_s]) begin
          win_vld_s = 1'b1;
          win_idx_s = OwnW'(k_s);
        end else begin
          win_vld_s = win_vld_s;
        end
      end
    end
  end

  assign ar_valid_s = win_vld_s && !full_s;
  assign push_s     = ar_valid_s && bus_if.mem_ar_ready_i;

  // Steer the winner's request onto the memory AR channel and return ready to it alone.
  always_comb begin
    win_addr_s            = {AxiAddrWidth{1'b0}};
    win_len_s             = 8'd0;
    bus_if.req_ar_ready_o = {NumReq{1'b0}};
    if (win_vld_s) begin
      win_addr_s = bus_if.req_ar_addr_i[int'(win_idx_s)*int'(AxiAddrWidth) +: AxiAddrWidth];
      win_len_s  = bus_if.req_ar_len_i[int'(win_idx_s)*8 +: 8];
    end else begin
      win_addr_s = {AxiAddrWidth{1'b0}};
    end
    if (push_s) begin
      bus_if.req_ar_ready_o[win_idx_s] = 1'b1;
    end else begin
      bus_if.req_ar_ready_o = {NumReq{1'b0}};
    end
  end

  assign bus_if.mem_ar_valid_o = ar_valid_s;
  assign bus_if.mem_ar_addr_o  = win_addr_s;
  assign bus_if.mem_ar_len_o   = win_len_s;

  // Route R beats to the head burst's owner; an empty tracker stalls the memory side.
  always_comb begin
    bus_if.req_r_valid_o = {NumReq{1'b0}};
    r_ready_s            = 1'b0;
    shift_en_o           = {NumStages{1'b0}};
    if (!empty_s) begin
      bus_if.req_r_valid_o[head_owner_s] = bus_if.mem_r_valid_i;
      r_ready_s                          = bus_if.req_r_ready_i[head_owner_s];
      shift_en_o                         = off_mem_r[rptr_r];
    end else begin
      r_ready_s = 1'b0;
    end
  end

  assign bus_if.mem_r_ready_o = r_ready_s;
  assign shift_valid_o        = !empty_s;
  assign r_hs_s               = bus_if.mem_r_valid_i && r_ready_s;
  assign pop_s                = r_hs_s && bus_if.mem_r_last_i;

  // Tracker FIFO, occupancy, round-robin pointer and AR grant lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r     <= {PtrW{1'b0}};
      rptr_r     <= {PtrW{1'b0}};
      cnt_r      <= {CntW{1'b0}};
      rr_ptr_r   <= {OwnW{1'b0}};
      lock_idx_r <= {OwnW{1'b0}};
      lock_r     <= 1'b0;
      for (int i = 0; i < int'(NumOutstanding); i++) begin
        owner_mem_r[i] <= {OwnW{1'b0}};
        off_mem_r[i]   <= {NumStages{1'b0}};
        len_mem_r[i]   <= 8'd0;
      end
    end else begin
      if (push_s) begin
        owner_mem_r[wptr_r] <= win_idx_s;
        off_mem_r[wptr_r]   <= win_addr_s[NumStages-1:0];
        len_mem_r[wptr_r]   <= win_len_s;
        wptr_r              <= wptr_r + 1'b1;
        rr_ptr_r            <= (win_idx_s == OwnW'(NumReq - 1)) ? {OwnW{1'b0}} : win_idx_s + 1'b1;
        lock_r              <= 1'b0;
      end else if (ar_valid_s) begin
        lock_r     <= 1'b1;
        lock_idx_r <= win_idx_s;
      end else begin
        lock_r <= lock_r;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end else begin
        rptr_r <= rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef ALIGN_SCHED_LEN_CHECK_EN
  logic [7:0] beat_cnt_r;
  logic       len_err_r;

  // Count beats of the head burst and flag a last that disagrees with the recorded length.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_r <= 8'd0;
      len_err_r  <= 1'b0;
    end else if (r_hs_s) begin
      if (bus_if.mem_r_last_i) begin
        beat_cnt_r <= 8'd0;
        len_err_r  <= len_err_r | (beat_cnt_r != head_len_s);
      end else begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
        len_err_r  <= len_err_r | (beat_cnt_r == head_len_s);
      end
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign len_err_o = len_err_r;
`else
  logic unused_len_s;
  assign unused_len_s = ^head_len_s;
  assign len_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_align_ar_scheduler.sv
// Directed-vector bench for align_ar_scheduler: arbitration, lock, full/empty and R routing.
module tb_align_ar_scheduler;
  localparam int unsigned NumReq = 2;
  localparam int unsigned AW     = 64;

  logic       clk_i;
  logic       rst_ni;
  logic [4:0] shift_en_o;
  logic       shift_valid_o;
  logic       len_err_o;
  int         vec_cnt;
  int         err_cnt;

`ifdef ALIGN_SCHED_LEN_CHECK_EN
  localparam logic ExpLenErr = 1'b1;
`else
  localparam logic ExpLenErr = 1'b0;
`endif

  align_ar_scheduler_if #(.NumReq(NumReq), .AxiAddrWidth(AW)) bus ();

  align_ar_scheduler #(
    .NumReq(NumReq), .AxiAddrWidth(AW), .AxiDataWidth(256), .NumOutstanding(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus_if(bus),
    .shift_en_o(shift_en_o), .shift_valid_o(shift_valid_o), .len_err_o(len_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // One R beat for the head burst; checks routing and shift value, then advances a cycle.
  task automatic r_beat(input int owner, input logic [4:0] off, input logic last);
    logic [1:0] exp_v;
    exp_v = 2'b01 << owner;
    bus.mem_r_valid_i = 1'b1;
    bus.mem_r_last_i  = last;
    #1;
    check_eq("r_valid_route", 64'(bus.req_r_valid_o), 64'(exp_v));
    check_eq("r_ready", 64'(bus.mem_r_ready_o), 64'd1);
    check_eq("shift_en", 64'(shift_en_o), 64'(off));
    tick();
    bus.mem_r_valid_i = 1'b0;
    bus.mem_r_last_i  = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [63:0] addr, input logic [7:0] len);
    bus.req_ar_addr_i[r*64 +: 64] = addr;
    bus.req_ar_len_i[r*8 +: 8]    = len;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_ni = 1'b0;
    bus.req_ar_valid_i = 2'b00;
    bus.req_ar_addr_i  = '0;
    bus.req_ar_len_i   = '0;
    bus.mem_ar_ready_i = 1'b0;
    bus.mem_r_valid_i  = 1'b0;
    bus.mem_r_last_i   = 1'b0;
    bus.req_r_ready_i  = 2'b00;
    tick();
    tick();
    check_eq("rst_ar_valid", 64'(bus.mem_ar_valid_o), 64'd0);
    check_eq("rst_ar_ready", 64'(bus.req_ar_ready_o), 64'd0);
    check_eq("rst_shift_valid", 64'(shift_valid_o), 64'd0);
    check_eq("rst_shift_en", 64'(shift_en_o), 64'd0);
    check_eq("rst_len_err", 64'(len_err_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Empty tracker: a beat from memory must stall.
    bus.mem_r_valid_i = 1'b1;
    bus.req_r_ready_i = 2'b11;
    #1;
    check_eq("empty_r_ready", 64'(bus.mem_r_ready_o), 64'd0);
    check_eq("empty_r_valid", 64'(bus.req_r_valid_o), 64'd0);
    bus.mem_r_valid_i = 1'b0;
    tick();

    // Single requester 0, addr 0x1005 len 3.
    set_req(0, 64'h1005, 8'd3);
    bus.req_ar_valid_i = 2'b01;
    bus.mem_ar_ready_i = 1'b1;
    #1;
    check_eq("t1_ar_valid", 64'(bus.mem_ar_valid_o), 64'd1);
    check_eq("t1_ar_addr", bus.mem_ar_addr_o, 64'h1005);
    check_eq("t1_ar_len", 64'(bus.mem_ar_len_o), 64'd3);
    check_eq("t1_ar_ready", 64'(bus.req_ar_ready_o), 64'd1);
    tick();
    bus.req_ar_valid_i = 2'b00;
    #1;
    check_eq("t1_shift_valid", 64'(shift_valid_o), 64'd1);
    r_beat(0, 5'd5, 1'b0);
    r_beat(0, 5'd5, 1'b0);
    r_beat(0, 5'd5, 1'b0);
    r_beat(0, 5'd5, 1'b1);
    #1;
    check_eq("t1_popped", 64'(shift_valid_o), 64'd0);

    // Reset returns rr pointer to 0; both requesters then alternate 0,1,0,1.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    set_req(0, 64'h2003, 8'd1);
    set_req(1, 64'h3011, 8'd0);
    bus.req_ar_valid_i = 2'b11;
    bus.mem_ar_ready_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      check_eq("t2_grant", 64'(bus.req_ar_ready_o), 64'(2'b01 << (g % 2)));
      check_eq("t2_addr", bus.mem_ar_addr_o, (g % 2 == 0) ? 64'h2003 : 64'h3011);
      tick();
    end
    bus.req_ar_valid_i = 2'b00;
    for (int b = 0; b < 4; b++) begin
      if (b % 2 == 0) begin
        r_beat(0, 5'd3, 1'b0);
        r_beat(0, 5'd3, 1'b1);
      end else begin
        r_beat(1, 5'd17, 1'b1);
      end
    end
    #1;
    check_eq("t2_drained", 64'(shift_valid_o), 64'd0);

    // Lock: requester 1 held while memory stalls, requester 0 waits.
    tick();
    set_req(1, 64'h4008, 8'd0);
    set_req(0, 64'h5001, 8'd0);
    bus.req_ar_valid_i = 2'b10;
    bus.mem_ar_ready_i = 1'b0;
    #1;
    check_eq("t3_valid", 64'(bus.mem_ar_valid_o), 64'd1);
    check_eq("t3_addr0", bus.mem_ar_addr_o, 64'h4008);
    tick();
    bus.req_ar_valid_i = 2'b11;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("t3_addr_held", bus.mem_ar_addr_o, 64'h4008);
      check_eq("t3_no_ready", 64'(bus.req_ar_ready_o), 64'd0);
      tick();
    end
    bus.mem_ar_ready_i = 1'b1;
    #1;
    check_eq("t3_hs_req1", 64'(bus.req_ar_ready_o), 64'b10);
    check_eq("t3_hs_addr", bus.mem_ar_addr_o, 64'h4008);
    tick();
    bus.req_ar_valid_i = 2'b01;
    #1;
    check_eq("t3_next_req0", 64'(bus.req_ar_ready_o), 64'b01);
    check_eq("t3_next_addr", bus.mem_ar_addr_o, 64'h5001);
    tick();
    bus.req_ar_valid_i = 2'b00;
    r_beat(1, 5'd8, 1'b1);
    r_beat(0, 5'd1, 1'b1);

    // Fill the tracker, then pop and push contend in one cycle.
    set_req(0, 64'h7007, 8'd0);
    bus.req_ar_valid_i = 2'b01;
    for (int n = 0; n < 8; n++) begin
      #1;
      check_eq("t4_fill", 64'(bus.req_ar_ready_o), 64'b01);
      tick();
    end
    #1;
    check_eq("t4_full_valid", 64'(bus.mem_ar_valid_o), 64'd0);
    check_eq("t4_full_ready", 64'(bus.req_ar_ready_o), 64'd0);
    bus.mem_r_valid_i = 1'b1;
    bus.mem_r_last_i  = 1'b1;
    bus.req_r_ready_i = 2'b01;
    #1;
    check_eq("t4_pop_ready", 64'(bus.mem_r_ready_o), 64'd1);
    check_eq("t4_no_bypass", 64'(bus.mem_ar_valid_o), 64'd0);
    tick();
    bus.mem_r_valid_i = 1'b0;
    bus.mem_r_last_i  = 1'b0;
    #1;
    check_eq("t4_after_pop", 64'(bus.req_ar_ready_o), 64'b01);
    tick();
    #1;
    check_eq("t4_full_again", 64'(bus.mem_ar_valid_o), 64'd0);
    bus.req_ar_valid_i = 2'b00;

    // Owner not ready: beat held, other requester's ready ignored.
    bus.req_r_ready_i = 2'b10;
    bus.mem_r_valid_i = 1'b1;
    bus.mem_r_last_i  = 1'b1;
    #1;
    check_eq("t5_r_ready", 64'(bus.mem_r_ready_o), 64'd0);
    check_eq("t5_r_valid", 64'(bus.req_r_valid_o), 64'b01);
    tick();
    bus.mem_r_valid_i  = 1'b0;
    bus.req_ar_valid_i = 2'b01;
    #1;
    check_eq("t5_no_pop", 64'(bus.mem_ar_valid_o), 64'd0);
    bus.req_ar_valid_i = 2'b00;
    bus.req_r_ready_i  = 2'b01;
    for (int n = 0; n < 8; n++) begin
      r_beat(0, 5'd7, 1'b1);
    end
    #1;
    check_eq("t5_drained", 64'(shift_valid_o), 64'd0);

    // Short burst: len 3 but last on the third beat.
    set_req(0, 64'h20, 8'd3);
    bus.req_ar_valid_i = 2'b01;
    bus.mem_ar_ready_i = 1'b1;
    #1;
    check_eq("t6_ar", 64'(bus.req_ar_ready_o), 64'b01);
    tick();
    bus.req_ar_valid_i = 2'b00;
    check_eq("t6_err_before", 64'(len_err_o), 64'd0);
    r_beat(0, 5'd0, 1'b0);
    r_beat(0, 5'd0, 1'b0);
    r_beat(0, 5'd0, 1'b1);
    #1;
    check_eq("t6_len_err", 64'(len_err_o), 64'(ExpLenErr));
    tick();
    tick();
    check_eq("t6_len_err_sticky", 64'(len_err_o), 64'(ExpLenErr));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/align_ar_scheduler.md
Name: align_ar_scheduler

Overview:
- Shares one AXI read port (AR/R) between NumReq vector-load requesters ahead of the staged R-channel byte-alignment pipeline.
- Arbitrates AR round-robin and records owner and address byte-offset per accepted burst in an in-order tracker FIFO.
- Steers R-beat valid/ready to the owning requester.
- Drives the per-stage shift enables of the alignment pipeline from the head tracker entry.

Parameters:
NumReq, 2, number of AR requesters (>=2)
AxiAddrWidth, 64, AR address width
AxiDataWidth, 256, R data width in bits; NumStages = $clog2(AxiDataWidth/8) (derived localparam)
NumOutstanding, 8, tracker depth, power of 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_ar_valid_i  in  NumReq  AR valid per requester
req_ar_ready_o  out  NumReq  AR ready per requester
req_ar_addr_i  in  NumReq*AxiAddrWidth  AR address per requester
req_ar_len_i  in  NumReq*8  AR burst length (beats-1) per requester
mem_ar_valid_o  out  1  AR valid to memory
mem_ar_ready_i  in  1  AR ready from memory
mem_ar_addr_o  out  AxiAddrWidth  granted address
mem_ar_len_o  out  8  granted len
mem_r_valid_i  in  1  R beat valid (alignment pipeline output)
mem_r_last_i  in  1  R last
mem_r_ready_o  out  1  R ready toward memory side
req_r_valid_o  out  NumReq  R valid per requester (one-hot or zero)
req_r_ready_i  in  NumReq  R ready per requester
shift_en_o  out  NumStages  per-stage shift enable for current burst
shift_valid_o  out  1  head tracker entry valid
len_err_o  out  1  sticky beat-count mismatch flag

Behaviour:
- Reset: all outputs 0; rr pointer 0; tracker count, read and write pointers 0; lock clear.
- Arbitration:
  - Round-robin from rr pointer over req_ar_valid_i.
  - Winner drives mem_ar_* combinationally; mem_ar_valid_o = winner exists && !full.
- Lock:
  - Once mem_ar_valid_o is high without handshake, grant is locked to that requester until mem_ar_ready_i.
  - Keeps AXI valid/addr stable; no re-arbitration while locked.
- AR handshake: req_ar_ready_o[g] = mem_ar_ready_i && granted && !full; all others 0.
- On AR handshake:
  - Push {owner=g, offset=addr[NumStages-1:0], len}; wptr wraps at NumOutstanding.
  - rr pointer = g+1 mod NumReq; lock clears.
- Full (count==NumOutstanding): mem_ar_valid_o=0 and no push. Push stays blocked in a cycle with a simultaneous pop (no bypass).
- Empty:
  - mem_r_ready_o=0, req_r_valid_o=0, shift_valid_o=0, shift_en_o=0.
  - R beats stall; they are never dropped.
- R routing (combinational, zero latency), head owner h:
  - req_r_valid_o[h] = mem_r_valid_i && !empty.
  - mem_r_ready_o = req_r_ready_i[h] && !empty.
- Pop: on an R handshake with mem_r_last_i, pop head; rptr wraps.
- Counter: count +1 on push only, -1 on pop only; simultaneous push and pop leaves it unchanged.
- shift_en_o = head offset bits; changes only on pop, so it is stable for all beats of a burst.
- No AXI ID reordering: memory returns bursts in AR order (single ID).
- Reset mid-burst: tracker cleared and lock cleared; any in-flight beats after reset see empty and stall.

Optional Feature:
- Macro: ALIGN_SCHED_LEN_CHECK_EN.
- Defined:
  - 8-bit beat counter increments per R handshake.
  - On a last beat, if counter != head len, or on a non-last beat where counter == head len, set len_err_o (sticky until reset).
  - Counter clears on pop.
- Undefined: no counter; len_err_o tied 0.

Test Plan:
- Single requester 0, addr 0x1005, len 3, mem_ar_ready_i=1 -> 1-cycle AR handshake; shift_en_o=5'b00101 (AxiDataWidth=256); 4 beats routed to req_r_valid_o[0]; pop after last; shift_valid_o drops.
- Both requesters valid every cycle with ready=1 -> grants alternate 0,1,0,1; tracker owners match grant order; R bursts routed in the same order.
- Requester 1 granted, mem_ar_ready_i low 3 cycles while requester 0 asserts -> mem_ar_addr_o held at req1 addr; req1 handshakes in cycle 4; req0 granted next.
- 8 ARs with no R returns -> count=8; mem_ar_valid_o=0. Last beat plus new AR in the same cycle -> pop only, count=7; AR accepted next cycle.
- req_r_ready_i[owner]=0 while mem_r_valid_i=1 -> mem_r_ready_o=0; beat held; no pop; other requester's ready has no effect.
- ALIGN_SCHED_LEN_CHECK_EN defined, len 3, last asserted on beat 2 -> len_err_o=1 next cycle and stays 1. Macro undefined -> len_err_o=0.
